mux3_sel_sequencer: RTL and testbench
=====================================

Name: mux3_sel_sequencer

Overview:
- Sequential select generator sitting directly upstream of the 3:1 single-bit mux; drives its 2-bit select `s`.
- Steps round-robin through channels 0→1→2→0, skipping masked-off channels.
- Holds each channel for a programmable dwell time.
- Flags valid selection and each channel change so downstream sampling logic can align to switch points.

Parameters:
- DWELL_W, 8, width of dwell input and internal dwell counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable; low forces IDLE.
- chan_mask  input  3  bit i = 1 enables channel i (bit0→in1, bit1→in2, bit2→in3).
- dwell  input  DWELL_W  cycles per channel; 0 treated as 1.
- s  output  2  mux select; only 2'b00, 2'b01, 2'b10 ever driven.
- s_valid  output  1  s points at an enabled channel and the sequencer is running.
- switch_pulse  output  1  one-cycle pulse in the first cycle a new s value is driven.

Interface (already decided): one clock; reset is synchronous and active-high. Clock port is `clk`, reset port is `rst`, both 1 bit. No other clocks; all outputs registered.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, s=2'b00, s_valid=0, switch_pulse=0, dwell counter cnt=0. rst dominates en and all other inputs.
- States: IDLE, RUN.
- IDLE:
  - If en=1 and chan_mask≠0: next cycle state=RUN, s=lowest enabled index, s_valid=1, switch_pulse=1, cnt=0, D=max(dwell,1) latched.
  - Otherwise remain IDLE, s_valid=0, s holds its last value.
- RUN, every cycle:
  - If en=0: next cycle IDLE, s_valid=0, s holds, switch_pulse=0.
  - Else if chan_mask==0: same as en=0.
  - Else if current s is masked off (mask changed mid-dwell): next cycle s=next enabled channel in round-robin order after s, switch_pulse=1, cnt=0, D relatched.
  - Else if cnt==D-1: next enabled channel after s in order 0→1→2→0.
    - If it differs from s: s updates, switch_pulse=1, cnt=0, D relatched.
    - If s is the only enabled channel: s holds, switch_pulse=0, cnt=0, D relatched.
  - Else: cnt=cnt+1, s holds, switch_pulse=0.
- Consequence: each enabled channel is held for exactly max(dwell,1) cycles. With dwell=1 and all channels enabled, s changes every cycle and switch_pulse stays high.
- dwell is sampled only at dwell-period start (entry to RUN and each relatch). Changes mid-period take effect next period.
- cnt width is DWELL_W. dwell=2^DWELL_W−1 must work without overflow.
- switch_pulse is never 1 while s_valid=0.
- Latency: en high at edge N → s_valid=1 after edge N+1 (one-cycle registered latency).

Optional Feature:
- Macro: MUX3_SEQ_HOLD_EN.
- Defined: adds input port `hold` (1 bit).
  - In RUN with hold=1: cnt freezes, s holds, switch_pulse=0, mask-change re-selection is deferred until hold drops.
  - en=0, chan_mask==0 and rst still take effect during hold.
  - hold is ignored in IDLE.
- Undefined: no `hold` port; behaviour exactly as above.

Test Plan:
- rst=1 for 2 cycles with en=1, mask=3'b111 → s=00, s_valid=0, switch_pulse=0 throughout. Release rst → s_valid=1 one cycle later, s=00, switch_pulse=1.
- mask=3'b111, dwell=3, en=1 for 12 cycles → s sequence 00,00,00,01,01,01,10,10,10,00,…; switch_pulse high in the first cycle of each group.
- mask=3'b101, dwell=2 → s alternates 00,00,10,10,00,… and never drives 01. Change mask to 3'b100 while s=00 → next cycle s=10, switch_pulse=1.
- mask=3'b010, dwell=0 → s=01 constant, s_valid=1, switch_pulse only on RUN entry.
- In RUN, drop en for 1 cycle → s_valid=0 next cycle, s held. Re-raise en → s restarts at lowest enabled channel with switch_pulse=1. Same response with mask=000.
- With MUX3_SEQ_HOLD_EN, dwell=4, hold=1 for 5 cycles mid-dwell → s frozen, then the remaining dwell count completes after hold=0. Total cycles on the channel = 4 + 5.

Source files
------------

// File: rtl/mux3_sel_sequencer.sv
// Round-robin select generator for a 3:1 mux with per-channel dwell and channel masking.
// Optional MUX3_SEQ_HOLD_EN adds a `hold` input that freezes the dwell count in RUN.
module mux3_sel_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         chan_mask,
  input  logic [DWELL_W-1:0] dwell,
`ifdef MUX3_SEQ_HOLD_EN
  input  logic               hold,
`endif
  output logic [1:0]         s,
  output logic               s_valid,
  output logic               switch_pulse
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg;
  logic [1:0]         s_reg;
  logic               s_valid_reg;
  logic               switch_reg;
  logic [DWELL_W-1:0] cnt_reg;
  logic [DWELL_W-1:0] d_reg;

  logic               hold_active;
  logic [DWELL_W-1:0] dwell_eff;
  logic [1:0]         next_chan;
  logic [1:0]         first_chan;

`ifdef MUX3_SEQ_HOLD_EN
  assign hold_active = hold;
`else
  assign hold_active = 1'b0;
`endif

  // A dwell of zero behaves exactly like a dwell of one.
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  function automatic logic [1:0] wrap_inc(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // Next enabled channel strictly after cur in 0->1->2->0 order; cur itself if it is the only one.
  function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [2:0] mask);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = wrap_inc(cur);
    c2 = wrap_inc(c1);
    if (mask[c1])      return c1;
    else if (mask[c2]) return c2;
    else               return cur;
  endfunction

  assign next_chan  = next_enabled(s_reg, chan_mask);
  assign first_chan = chan_mask[0] ? 2'd0 : (chan_mask[1] ? 2'd1 : 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      s_reg       <= 2'd0;
      s_valid_reg <= 1'b0;
      switch_reg  <= 1'b0;
      cnt_reg     <= '0;
      d_reg       <= DWELL_W'(1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (en && chan_mask != 3'b000) begin
            state_reg   <= RUN;
            s_reg       <= first_chan;
            s_valid_reg <= 1'b1;
            switch_reg  <= 1'b1;
            cnt_reg     <= '0;
            d_reg       <= dwell_eff;
          end else begin
            s_valid_reg <= 1'b0;
            switch_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (!en || chan_mask == 3'b000) begin
            state_reg   <= IDLE;
            s_valid_reg <= 1'b0;
            switch_reg  <= 1'b0;
          end else if (hold_active) begin
            // Everything, including re-selection after a mask change, waits for hold to drop.
            switch_reg <= 1'b0;
          end else if (!chan_mask[s_reg]) begin
            s_reg      <= next_chan;
            switch_reg <= 1'b1;
            cnt_reg    <= '0;
            d_reg      <= dwell_eff;
          end else if (cnt_reg == d_reg - DWELL_W'(1)) begin
            s_reg      <= next_chan;
            switch_reg <= (next_chan != s_reg);
            cnt_reg    <= '0;
            d_reg      <= dwell_eff;
          end else begin
            cnt_reg    <= cnt_reg + DWELL_W'(1);
            switch_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          s_valid_reg <= 1'b0;
          switch_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign s            = s_reg;
  assign s_valid      = s_valid_reg;
  assign switch_pulse = switch_reg;

endmodule

// File: tb/tb_mux3_sel_sequencer.sv
// Bench for mux3_sel_sequencer: directed vector table, dwell-limit and hold sequences,
// then random stimulus against a remaining-cycles reference model.
module tb_mux3_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] chan_mask = 3'b000;
  logic [7:0] dwell = 8'd0;
  logic       hold = 1'b0;
  logic [1:0] s;
  logic       s_valid;
  logic       switch_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux3_sel_sequencer #(.DWELL_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .chan_mask    (chan_mask),
    .dwell        (dwell),
`ifdef MUX3_SEQ_HOLD_EN
    .hold         (hold),
`endif
    .s            (s),
    .s_valid      (s_valid),
    .switch_pulse (switch_pulse)
  );

  // Reference model: tracks how many more cycles the current channel must be held.
  bit m_run   = 1'b0;
  int m_s     = 0;
  int m_left  = 0;
  bit m_pulse = 1'b0;

  function automatic int ref_next(input int cur, input logic [2:0] mask);
    for (int k = 1; k <= 3; k++)
      if (mask[(cur + k) % 3]) return (cur + k) % 3;
    return cur;
  endfunction

  function automatic int ref_lowest(input logic [2:0] mask);
    for (int k = 0; k < 3; k++)
      if (mask[k]) return k;
    return 0;
  endfunction

  task automatic model_update();
    int period;
    int n;
    period = (dwell == 0) ? 1 : int'(dwell);
    if (rst) begin
      m_run = 1'b0; m_s = 0; m_pulse = 1'b0;
    end else if (!m_run) begin
      m_pulse = 1'b0;
      if (en && chan_mask != 0) begin
        m_run = 1'b1; m_s = ref_lowest(chan_mask); m_pulse = 1'b1; m_left = period - 1;
      end
    end else if (!en || chan_mask == 0) begin
      m_run = 1'b0; m_pulse = 1'b0;
    end else if (hold) begin
      m_pulse = 1'b0;
    end else if (!chan_mask[m_s]) begin
      m_s = ref_next(m_s, chan_mask); m_pulse = 1'b1; m_left = period - 1;
    end else if (m_left == 0) begin
      n = ref_next(m_s, chan_mask);
      m_pulse = (n != m_s); m_s = n; m_left = period - 1;
    end else begin
      m_left--; m_pulse = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mask;
    logic [7:0] dwell;
    logic [1:0] s;
    logic       v;
    logic       p;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [2:0] m, input logic [7:0] d,
                     input logic [1:0] es, input logic ev, input logic ep);
    vec_t x;
    x.rst = r; x.en = e; x.mask = m; x.dwell = d; x.s = es; x.v = ev; x.p = ep;
    tbl.push_back(x);
  endtask

  initial begin
    int cnt;
    int ok;

    // reset held with en high, then mask=111 dwell=3
    add(1, 1, 3'b111, 3, 0, 0, 0);
    add(1, 1, 3'b111, 3, 0, 0, 0);
    add(0, 1, 3'b111, 3, 0, 1, 1);
    add(0, 1, 3'b111, 3, 0, 1, 0);
    add(0, 1, 3'b111, 3, 0, 1, 0);
    add(0, 1, 3'b111, 3, 1, 1, 1);
    add(0, 1, 3'b111, 3, 1, 1, 0);
    add(0, 1, 3'b111, 3, 1, 1, 0);
    add(0, 1, 3'b111, 3, 2, 1, 1);
    add(0, 1, 3'b111, 3, 2, 1, 0);
    add(0, 1, 3'b111, 3, 2, 1, 0);
    add(0, 1, 3'b111, 3, 0, 1, 1);
    // en drop, then mask=101 dwell=2, then mask=100 while on channel 0
    add(0, 0, 3'b111, 3, 0, 0, 0);
    add(0, 1, 3'b101, 2, 0, 1, 1);
    add(0, 1, 3'b101, 2, 0, 1, 0);
    add(0, 1, 3'b101, 2, 2, 1, 1);
    add(0, 1, 3'b101, 2, 2, 1, 0);
    add(0, 1, 3'b101, 2, 0, 1, 1);
    add(0, 1, 3'b100, 2, 2, 1, 1);
    add(0, 1, 3'b100, 2, 2, 1, 0);
    add(0, 1, 3'b100, 2, 2, 1, 0);
    add(0, 1, 3'b100, 2, 2, 1, 0);
    // mask to zero drops to idle, single channel with dwell 0, then dwell 1 on all channels
    add(0, 1, 3'b000, 2, 2, 0, 0);
    add(0, 1, 3'b010, 0, 1, 1, 1);
    add(0, 1, 3'b010, 0, 1, 1, 0);
    add(0, 1, 3'b010, 0, 1, 1, 0);
    add(0, 1, 3'b111, 1, 2, 1, 1);
    add(0, 1, 3'b111, 1, 0, 1, 1);
    add(0, 1, 3'b111, 1, 1, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; en = tbl[i].en; chan_mask = tbl[i].mask; dwell = tbl[i].dwell;
      step();
      $display("vec %0d: rst=%0b en=%0b mask=%b dwell=%0d -> s=%0d v=%0b p=%0b",
               i, rst, en, chan_mask, dwell, s, s_valid, switch_pulse);
      check($sformatf("vec%0d_s", i), int'(s), int'(tbl[i].s));
      check($sformatf("vec%0d_valid", i), int'(s_valid), int'(tbl[i].v));
      check($sformatf("vec%0d_pulse", i), int'(switch_pulse), int'(tbl[i].p));
    end

    // maximum dwell: channel 0 must be held for exactly 255 cycles
    rst = 1; step();
    rst = 0; en = 1; chan_mask = 3'b011; dwell = 8'd255;
    step();
    check("maxdwell_entry_pulse", int'(switch_pulse), 1);
    cnt = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (s != 2'd0) break;
      cnt++;
    end
    $display("seq maxdwell: cycles on ch0 = %0d, then s=%0d p=%0b", cnt, s, switch_pulse);
    check("maxdwell_cycles", cnt, 255);
    check("maxdwell_next_s", int'(s), 1);
    check("maxdwell_next_pulse", int'(switch_pulse), 1);

`ifdef MUX3_SEQ_HOLD_EN
    // hold for 5 cycles mid-dwell extends the channel to 4 + 5 cycles
    rst = 1; step();
    rst = 0; en = 1; chan_mask = 3'b011; dwell = 8'd4;
    step();
    step();
    hold = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_frozen_s", int'(s), 0);
      check("hold_no_pulse", int'(switch_pulse), 0);
    end
    hold = 0;
    cnt = 7;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s != 2'd0) break;
      cnt++;
    end
    $display("seq hold: cycles on ch0 = %0d", cnt);
    check("hold_total_cycles", cnt, 9);
`endif

    // random stimulus against the reference model
    rst = 1; step();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 5) == 0) chan_mask = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) dwell = 8'($urandom_range(0, 4));
`ifdef MUX3_SEQ_HOLD_EN
      hold = ($urandom_range(0, 3) == 0);
`endif
      step();
      $display("rnd %0d: rst=%0b en=%0b hold=%0b mask=%b dwell=%0d -> s=%0d v=%0b p=%0b",
               i, rst, en, hold, chan_mask, dwell, s, s_valid, switch_pulse);
      check("rnd_valid", int'(s_valid), int'(m_run));
      check("rnd_pulse", int'(switch_pulse), int'(m_pulse));
      if (m_run) check("rnd_s", int'(s), m_s);
      ok = (s != 2'b11) && !(switch_pulse && !s_valid);
      check("rnd_output_legal", ok, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
